// File: rtl/mux_scan_nx1.sv
// N-to-1 multiplexer with a registered valid/ready output stage.
// Manual mode follows sel_in; auto mode round-robins the enabled channels with a dwell time.
module mux_scan_nx1 #(
  parameter int N       = 16,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     din,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [N-1:0]       ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  output logic [W-1:0]       y,
  output logic [SEL_W-1:0]   y_ch,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               busy,
  output logic               wrap,
  output logic [1:0]         dbg_state
);

  // Handshake: a sample transfers on any rising clk edge where y_valid & y_ready.
  // The stage reloads only when empty or draining (!y_valid | y_ready); while
  // y_valid & !y_ready, y, y_ch and y_valid do not change.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   cur, cur_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               wrap_nxt;

  logic               loadable;
  logic               load;
  logic [W-1:0]       ld_data;
  logic [SEL_W-1:0]   ld_ch;

  logic [W-1:0]       sel_data;
  logic [W-1:0]       cur_data;
  logic [SEL_W-1:0]   lowest_ch;
  logic [SEL_W-1:0]   above_ch;
  logic               above_found;
  logic [SEL_W-1:0]   adv_ch;
  logic               adv_wrap;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   cnt_inc;
  logic               due;
  logic               scan_exit;

  assign loadable  = !y_valid || y_ready;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign cnt_inc   = {1'b0, cnt} + (DWELL_W+1)'(1);
  // >= rather than == so that shrinking dwell mid-count samples at once
  // instead of running the counter all the way round.
  assign due       = cnt_inc >= {1'b0, dwell_eff};
  assign scan_exit = !mode || (ch_en == '0);

  // Channel muxes; out-of-range indices read as zero.
  always_comb begin
    sel_data = '0;
    cur_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_in == SEL_W'(k)) sel_data = din[k*W +: W];
      if (cur == SEL_W'(k))    cur_data = din[k*W +: W];
    end
  end

  // Lowest enabled channel, and lowest enabled channel strictly above cur.
  always_comb begin
    lowest_ch   = '0;
    above_ch    = '0;
    above_found = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (ch_en[i]) begin
        lowest_ch = SEL_W'(i);
        if (i > int'(cur)) begin
          above_ch    = SEL_W'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign adv_ch   = above_found ? above_ch : lowest_ch;
  assign adv_wrap = !above_found;

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    load      = 1'b0;
    ld_data   = '0;
    ld_ch     = '0;
    case (state)
      ST_IDLE: begin
        if (!mode) begin
          if (loadable) begin
            load    = 1'b1;
            ld_data = sel_data;
            ld_ch   = sel_in;
          end
        end else if (start && (ch_en != '0)) begin
          state_nxt = ST_SCAN;
          cur_nxt   = lowest_ch;
          cnt_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_exit) begin
          state_nxt = ST_IDLE;
        end else if (due) begin
          if (loadable) begin
            load     = 1'b1;
            ld_data  = cur_data;
            ld_ch    = cur;
            cnt_nxt  = '0;
            cur_nxt  = adv_ch;
            wrap_nxt = adv_wrap;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else begin
          cnt_nxt = cnt_inc[DWELL_W-1:0];
        end
      end
      ST_HOLD: begin
        // The pending sample reads din[cur] on the cycle it actually loads.
        if (scan_exit) begin
          state_nxt = ST_IDLE;
        end else if (loadable) begin
          load      = 1'b1;
          ld_data   = cur_data;
          ld_ch     = cur;
          cnt_nxt   = '0;
          cur_nxt   = adv_ch;
          wrap_nxt  = adv_wrap;
          state_nxt = ST_SCAN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (load) begin
      y       <= ld_data;
      y_ch    <= ld_ch;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (y_valid && !y_ready) |=> (y_valid && $stable(y) && $stable(y_ch)));

  a_no_idle_scan_load: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE && mode) |-> !load);

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: a 16x1 instance for manual/auto/backpressure/reset
// cases and a 5x4 instance for out-of-range manual selects.
module tb_mux_scan_nx1;

  logic clk;
  logic rst_n;

  // 16x1 instance
  logic [15:0] din;
  logic        mode;
  logic [3:0]  sel_in;
  logic [15:0] ch_en;
  logic [7:0]  dwell;
  logic        start;
  logic [0:0]  y;
  logic [3:0]  y_ch;
  logic        y_valid;
  logic        y_ready;
  logic        busy;
  logic        wrap;
  logic [1:0]  dbg_state;

  // 5x4 instance
  logic [19:0] din5;
  logic [2:0]  sel5;
  logic [3:0]  y5;
  logic [2:0]  y_ch5;
  logic        y_valid5;
  logic        busy5;
  logic        wrap5;
  logic [1:0]  dbg_state5;

  int total;
  int bad;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] sel;
    logic       exp_y;
  } vec_t;
  vec_t tbl[16];

  mux_scan_nx1 #(.N(16), .W(1), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
    .ch_en(ch_en), .dwell(dwell), .start(start), .y(y), .y_ch(y_ch),
    .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .wrap(wrap),
    .dbg_state(dbg_state)
  );

  mux_scan_nx1 #(.N(5), .W(4), .DWELL_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .din(din5), .mode(1'b0), .sel_in(sel5),
    .ch_en(5'b0), .dwell(8'd1), .start(1'b0), .y(y5), .y_ch(y_ch5),
    .y_valid(y_valid5), .y_ready(1'b1), .busy(busy5), .wrap(wrap5),
    .dbg_state(dbg_state5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for y_valid after the next edges; checks gap, channel, data, wrap.
  task automatic wait_sample(input string name, input int exp_ch, input bit exp_wrap,
                             input int exp_gap);
    int  n;
    bit  seen;
    bit  stray;
    n = 0;
    seen = 1'b0;
    stray = 1'b0;
    while (!seen && n < 50) begin
      step();
      n++;
      if (y_valid) seen = 1'b1;
      else if (wrap) stray = 1'b1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_gap"},  32'(n),       32'(exp_gap));
      chk({name, "_ch"},   32'(y_ch),    32'(exp_ch));
      chk({name, "_y"},    32'(y),       32'(din[exp_ch]));
      chk({name, "_wrap"}, 32'(wrap),    32'(exp_wrap));
      chk({name, "_busy"}, 32'(busy),    32'd1);
    end
    chk({name, "_stray_wrap"}, 32'(stray), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    din = 16'hA5C3;
    mode = 1'b0;
    sel_in = '0;
    ch_en = '0;
    dwell = 8'd3;
    start = 1'b0;
    y_ready = 1'b1;
    din5 = '0;
    sel5 = '0;

    // expected bits of 16'hA5C3, LSB first
    tbl[0]  = '{4'd0,  1'b1}; tbl[1]  = '{4'd1,  1'b1};
    tbl[2]  = '{4'd2,  1'b0}; tbl[3]  = '{4'd3,  1'b0};
    tbl[4]  = '{4'd4,  1'b0}; tbl[5]  = '{4'd5,  1'b0};
    tbl[6]  = '{4'd6,  1'b1}; tbl[7]  = '{4'd7,  1'b1};
    tbl[8]  = '{4'd8,  1'b1}; tbl[9]  = '{4'd9,  1'b0};
    tbl[10] = '{4'd10, 1'b1}; tbl[11] = '{4'd11, 1'b0};
    tbl[12] = '{4'd12, 1'b0}; tbl[13] = '{4'd13, 1'b1};
    tbl[14] = '{4'd14, 1'b0}; tbl[15] = '{4'd15, 1'b1};

    rst_n = 1'b0;
    step();
    step();
    chk("rst_y",       32'(y),        32'd0);
    chk("rst_y_ch",    32'(y_ch),     32'd0);
    chk("rst_y_valid", 32'(y_valid),  32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_wrap",    32'(wrap),     32'd0);
    chk("rst_state",   32'(dbg_state), 32'd0);
    chk("rst_valid5",  32'(y_valid5), 32'd0);
    #3;
    rst_n = 1'b1;

    // 1: manual select, one-cycle latency
    for (int i = 0; i < 16; i++) begin
      sel_in = tbl[i].sel;
      step();
      chk($sformatf("man_y_%0d", i),     32'(y),       32'(tbl[i].exp_y));
      chk($sformatf("man_ch_%0d", i),    32'(y_ch),    32'(tbl[i].sel));
      chk($sformatf("man_valid_%0d", i), 32'(y_valid), 32'd1);
    end

    // 2: auto scan over channels 0,4,7
    mode = 1'b1;
    ch_en = 16'h0091;
    dwell = 8'd3;
    step();
    chk("auto_idle_drain", 32'(y_valid), 32'd0);
    pulse_start();
    chk("auto_busy", 32'(busy), 32'd1);
    wait_sample("a0", 0, 1'b0, 3);
    wait_sample("a4", 4, 1'b0, 3);
    wait_sample("a7", 7, 1'b1, 3);
    wait_sample("a0b", 0, 1'b0, 3);

    // 3: backpressure on channel 4, no skip afterwards
    step();
    y_ready = 1'b0;
    wait_sample("bp4", 4, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_valid_%0d", i), 32'(y_valid), 32'd1);
      chk($sformatf("bp_ch_%0d", i),    32'(y_ch),    32'd4);
      chk($sformatf("bp_y_%0d", i),     32'(y),       32'(din[4]));
      chk($sformatf("bp_busy_%0d", i),  32'(busy),    32'd1);
    end
    y_ready = 1'b1;
    wait_sample("bp7", 7, 1'b1, 1);
    wait_sample("bp0", 0, 1'b0, 3);

    // 4a: ch_en cleared exits scan; start with empty mask ignored
    ch_en = '0;
    step();
    chk("exit_busy",  32'(busy),    32'd0);
    chk("exit_valid", 32'(y_valid), 32'd0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("empty_busy_%0d", i),  32'(busy),    32'd0);
      chk($sformatf("empty_valid_%0d", i), 32'(y_valid), 32'd0);
    end

    // 4b: single channel repeats with wrap every sample
    ch_en = 16'h0100;
    pulse_start();
    wait_sample("one_a", 8, 1'b1, 3);
    wait_sample("one_b", 8, 1'b1, 3);
    wait_sample("one_c", 8, 1'b1, 3);
    ch_en = '0;
    step();

    // 4c: dwell=0 samples every cycle like dwell=1
    dwell = 8'd0;
    ch_en = 16'h0100;
    step();
    pulse_start();
    wait_sample("dw0_a", 8, 1'b1, 1);
    wait_sample("dw0_b", 8, 1'b1, 1);
    wait_sample("dw0_c", 8, 1'b1, 1);
    ch_en = '0;
    step();
    chk("dw0_exit_busy", 32'(busy), 32'd0);

    // 5: asynchronous reset between edges mid-scan
    dwell = 8'd3;
    ch_en = 16'h0091;
    step();
    pulse_start();
    wait_sample("r0", 0, 1'b0, 3);
    wait_sample("r4", 4, 1'b0, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_y",     32'(y),       32'd0);
    chk("arst_y_ch",  32'(y_ch),    32'd0);
    chk("arst_valid", 32'(y_valid), 32'd0);
    chk("arst_busy",  32'(busy),    32'd0);
    chk("arst_wrap",  32'(wrap),    32'd0);
    step();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("post_rst_busy_%0d", i),  32'(busy),      32'd0);
      chk($sformatf("post_rst_valid_%0d", i), 32'(y_valid),   32'd0);
      chk($sformatf("post_rst_state_%0d", i), 32'(dbg_state), 32'd0);
    end
    pulse_start();
    wait_sample("rs0", 0, 1'b0, 3);

    // 6: N=5, W=4 manual with out-of-range selects
    for (int r = 0; r < 2; r++) begin
      din5 = 20'($urandom);
      for (int s = 0; s < 8; s++) begin
        logic [19:0] d;
        logic [3:0]  e;
        d = din5;
        e = (s < 5) ? d[s*4 +: 4] : 4'd0;
        sel5 = 3'(s);
        exp_q.push_back(e);
        step();
        chk($sformatf("n5_y_%0d_%0d", r, s),     32'(y5),       32'(exp_q.pop_front()));
        chk($sformatf("n5_ch_%0d_%0d", r, s),    32'(y_ch5),    32'(s));
        chk($sformatf("n5_valid_%0d_%0d", r, s), 32'(y_valid5), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
